// File: rtl/store_commit_buffer.sv
// Post-commit store queue: formats retired stores into word/lane/mask entries,
// drains them in order to the data cache, and offers a same-cycle load lookup.
module store_commit_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [2:0]               in_type,
  output logic                     in_ready,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  output logic [3:0]               mem_mask,
  input  logic                     mem_ack,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_conflict,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_W - 2;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [WW-1:0]     waddr_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [3:0]        mask_q  [DEPTH];

  logic              enq_s;
  logic              pop_s;
  logic [3:0]        new_mask_s;
  logic [DATA_W-1:0] new_data_s;

  function automatic logic [3:0] form_mask(input logic [2:0] t, input logic [1:0] b);
    logic [3:0] m;
    case (t)
      3'b000:  m = 4'b0001 << b;
      3'b001:  m = b[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] form_data(input logic [2:0] t, input logic [1:0] b,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (t)
      3'b000:  r = {{(DATA_W-8){1'b0}}, d[7:0]} << {b, 3'b000};
      3'b001:  r = {{(DATA_W-16){1'b0}}, d[15:0]} << {b[1], 4'b0000};
      default: r = d;
    endcase
    return r;
  endfunction

  assign in_ready = (count_q < CW'(DEPTH));
  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = {waddr_q[head_q], 2'b00};
  assign mem_data = data_q[head_q];
  assign mem_mask = mask_q[head_q];
  assign empty    = (count_q == {CW{1'b0}});
  assign count    = count_q;

  // Handshake qualification, pointer/count/valid next state.
  always_comb begin
    enq_s      = in_valid && in_ready;
    pop_s      = (state_q == S_REQ) && mem_ack;
    new_mask_s = form_mask(in_type, in_addr[1:0]);
    new_data_s = form_data(in_type, in_addr[1:0], in_data);
    head_d     = pop_s ? head_q + {{(PW-1){1'b0}}, 1'b1} : head_q;
    tail_d     = enq_s ? tail_q + {{(PW-1){1'b0}}, 1'b1} : tail_q;
    count_d    = count_q + CW'(enq_s) - CW'(pop_s);
    valid_d    = valid_q;
    if (pop_s) begin
      valid_d[head_q] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (enq_s) begin
      valid_d[tail_q] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
  end

  // Queue control and drain FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      case (state_q)
        S_IDLE:  state_q <= (count_q != {CW{1'b0}}) ? S_REQ : S_IDLE;
        S_REQ:   state_q <= (pop_s && count_d == {CW{1'b0}}) ? S_IDLE : S_REQ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Entry payload storage; contents are meaningless unless the valid bit is set.
  always_ff @(posedge clk) begin
    if (enq_s && !rst) begin
      waddr_q[tail_q] <= in_addr[ADDR_W-1:2];
      data_q[tail_q]  <= new_data_s;
      mask_q[tail_q]  <= new_mask_s;
    end
  end

  // Walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    logic          match;
    ld_hit      = 1'b0;
    ld_conflict = 1'b0;
    ld_data     = '0;
    idx         = '0;
    match       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx   = head_q + PW'(i);
      match = valid_q[idx] && (waddr_q[idx] == ld_addr[ADDR_W-1:2]);
      if (match) begin
        ld_hit      = (mask_q[idx] == 4'b1111);
        ld_conflict = (mask_q[idx] != 4'b1111);
        ld_data     = (mask_q[idx] == 4'b1111) ? data_q[idx] : '0;
      end else begin
        ld_hit      = ld_hit;
        ld_conflict = ld_conflict;
        ld_data     = ld_data;
      end
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Randomized and directed bench for store_commit_buffer with a queue-based
// reference model and a decoupled scoreboard monitor on the cache port.
module tb_store_commit_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_data = 32'h0;
  logic [2:0]  in_type = 3'h0;
  logic        in_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_mask;
  logic        mem_ack = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_conflict;
  logic        empty;
  logic [2:0]  count;

  always #5 clk = ~clk;

  store_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_type(in_type), .in_ready(in_ready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_mask(mem_mask), .mem_ack(mem_ack), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict), .empty(empty),
    .count(count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  ent_t mq[$];
  ent_t sbq[$];
  bit   mreq = 1'b0;
  bit   started = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t form(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    ent_t e;
    int   sh;
    e.addr = {a[31:2], 2'b00};
    if (t == 3'd0) begin
      sh = int'(a[1:0]);
      e.mask = 4'b0001 << sh;
      e.data = {24'h0, d[7:0]} << (8 * sh);
    end else if (t == 3'd1) begin
      sh = a[1] ? 2 : 0;
      e.mask = 4'b0011 << sh;
      e.data = {16'h0, d[15:0]} << (8 * sh);
    end else begin
      e.mask = 4'hF;
      e.data = d;
    end
    return e;
  endfunction

  task automatic ld_model(input logic [31:0] la, output bit h, output bit c, output logic [31:0] d);
    h = 1'b0; c = 1'b0; d = 32'h0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr[31:2] == la[31:2]) begin
        h = (mq[i].mask == 4'hF);
        c = !h;
        d = h ? mq[i].data : 32'h0;
        break;
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                      input bit ack, input logic [31:0] la, input bit r);
    int   oc;
    bit   enq;
    ent_t e;
    in_valid = v; in_addr = a; in_data = d; in_type = t;
    mem_ack = ack; ld_addr = la; rst = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      sbq.delete();
      mreq = 1'b0;
    end else begin
      oc  = mq.size();
      enq = v && (oc < DEPTH);
      if (mreq && ack) e = mq.pop_front();
      if (enq) begin
        e = form(a, d, t);
        mq.push_back(e);
        sbq.push_back(e);
      end
      mreq = mreq ? (mq.size() != 0) : (oc != 0);
    end
    #1;
  endtask

  task automatic idle(input bit ack, input logic [31:0] la);
    step(1'b0, 32'h0, 32'h0, 3'd0, ack, la, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || mreq) && n < 40) begin
      idle(1'b1, 32'h0);
      n++;
    end
    if (mq.size() != 0 || mreq) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left after %0d cycles", mq.size(), n);
    end
  endtask

  // Scoreboard monitor: compares the cache port and load lookup on every falling edge.
  always @(negedge clk) begin
    bit          h, c;
    logic [31:0] d;
    ent_t        e;
    if (started && !rst) begin
      chk("mem_req", {31'h0, mem_req}, {31'h0, mreq});
      chk("count", {29'h0, count}, mq.size());
      chk("in_ready", {31'h0, in_ready}, {31'h0, mq.size() < DEPTH});
      chk("empty", {31'h0, empty}, {31'h0, mq.size() == 0});
      ld_model(ld_addr, h, c, d);
      chk("ld_hit", {31'h0, ld_hit}, {31'h0, h});
      chk("ld_conflict", {31'h0, ld_conflict}, {31'h0, c});
      chk("ld_data", ld_data, d);
      if (mem_req) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: mem_req=1 with nothing expected, addr %0h", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, sbq[0].addr);
          chk("mem_data", mem_data, sbq[0].data);
          chk("mem_mask", {28'h0, mem_mask}, {28'h0, sbq[0].mask});
          if (mem_ack) e = sbq.pop_front();
        end
      end
    end
  end

  initial begin
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h0, 1'b1);
    started = 1'b1;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_ld_hit", {31'h0, ld_hit}, 32'h0);
    chk("rst_ld_conflict", {31'h0, ld_conflict}, 32'h0);

    // Single SW with ack held high: request one edge after the enqueue edge.
    step(1'b1, 32'h100, 32'hDEADBEEF, 3'd2, 1'b1, 32'h0, 1'b0);
    chk("sw_req_early", {31'h0, mem_req}, 32'h0);
    idle(1'b1, 32'h0);
    chk("sw_req", {31'h0, mem_req}, 32'h1);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_data", mem_data, 32'hDEADBEEF);
    chk("sw_mask", {28'h0, mem_mask}, 32'hF);
    idle(1'b1, 32'h0);
    chk("sw_empty", {31'h0, empty}, 32'h1);

    step(1'b1, 32'h203, 32'h5A, 3'd0, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 32'h0);
    chk("sb_addr", mem_addr, 32'h200);
    chk("sb_data", mem_data, 32'h5A000000);
    chk("sb_mask", {28'h0, mem_mask}, 32'h8);
    idle(1'b1, 32'h0);
    step(1'b1, 32'h206, 32'h1234, 3'd1, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 32'h0);
    chk("sh_data", mem_data, 32'h12340000);
    chk("sh_mask", {28'h0, mem_mask}, 32'hC);
    idle(1'b1, 32'h0);
    drain();

    // Fill to capacity with the cache stalled, then release one ack.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h300 + 32'(4 * i), $urandom, 3'd2, 1'b0, 32'h0, 1'b0);
    chk("full_ready", {31'h0, in_ready}, 32'h0);
    chk("full_count", {29'h0, count}, 32'h4);
    step(1'b1, 32'h400, 32'h0BAD0BAD, 3'd2, 1'b0, 32'h0, 1'b0);
    chk("full_drop", {29'h0, count}, 32'h4);
    idle(1'b1, 32'h0);
    chk("pop_count", {29'h0, count}, 32'h3);
    chk("pop_ready", {31'h0, in_ready}, 32'h1);
    chk("pop_addr", mem_addr, 32'h304);
    idle(1'b0, 32'h0);
    chk("pop_addr_stable", mem_addr, 32'h304);
    drain();

    // Load forwarding and partial-overlap stall.
    step(1'b1, 32'h40, 32'h11111111, 3'd2, 1'b0, 32'h42, 1'b0);
    step(1'b1, 32'h40, 32'h22222222, 3'd2, 1'b0, 32'h42, 1'b0);
    chk("fwd_hit", {31'h0, ld_hit}, 32'h1);
    chk("fwd_data", ld_data, 32'h22222222);
    step(1'b1, 32'h41, 32'h77, 3'd0, 1'b0, 32'h42, 1'b0);
    chk("part_conflict", {31'h0, ld_conflict}, 32'h1);
    chk("part_hit", {31'h0, ld_hit}, 32'h0);
    idle(1'b0, 32'h80);
    chk("miss_hit", {31'h0, ld_hit}, 32'h0);
    chk("miss_conflict", {31'h0, ld_conflict}, 32'h0);
    drain();

    // Saturated flow: full buffer, ack and in_valid every cycle, across pointer wrap.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h600 + 32'(4 * i), $urandom, 3'($urandom_range(0, 4)), 1'b0, 32'h600, 1'b0);
    for (int i = 0; i < 14; i++)
      step(1'b1, 32'h700 + 32'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 4)), 1'b1,
           32'h700 + 32'($urandom_range(0, 63)), 1'b0);
    drain();

    // Reset while a request is in flight.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h800 + 32'(4 * i), $urandom, 3'd2, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 32'h0);
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    step(1'b1, 32'h900, 32'h1, 3'd2, 1'b1, 32'h0, 1'b1);
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_count", {29'h0, count}, 32'h0);
    chk("mid_rst_empty", {31'h0, empty}, 32'h1);
    chk("mid_rst_ready", {31'h0, in_ready}, 32'h1);
    step(1'b1, 32'hA00, 32'hCAFEF00D, 3'd2, 1'b1, 32'hA00, 1'b0);
    drain();

    // Random mix over a small address window to exercise lookup overlap.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 3) != 0, 32'h40 + 32'($urandom_range(0, 15)), $urandom,
           3'($urandom_range(0, 5)), $urandom_range(0, 3) != 0,
           32'h40 + 32'($urandom_range(0, 15)), 1'b0);
    drain();
    idle(1'b0, 32'h0);
    chk("final_empty", {31'h0, empty}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Post-commit store queue sitting between the reorder buffer's store-retire port and the data cache write port.
- Accepts committed stores (byte address, data, SB/SH/SW subtype), converts each to a word address, a lane-aligned data word and a byte mask, and drains them in order to the cache with a req/ack handshake.
- Provides a same-cycle load lookup so the load unit can forward full-word store data or stall on partial overlap.
- in_ready drives the ROB's cacheWriteDone input.

Parameters:
DEPTH, 4, number of queued stores (power of two, 2..16)
ADDR_W, 32, byte address width
DATA_W, 32, data width (fixed 32; byte lanes = 4)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  ROB presents a committed store this cycle
in_addr  input  ADDR_W  store byte address
in_data  input  DATA_W  store value, right-justified (byte in [7:0], half in [15:0])
in_type  input  3  000=SB, 001=SH, 010=SW; any other code is treated as SW
in_ready  output  1  buffer can accept a store this cycle (to ROB cacheWriteDone)
mem_req  output  1  write request to data cache
mem_addr  output  ADDR_W  word-aligned address of head entry ({word_addr, 2'b00})
mem_data  output  DATA_W  lane-aligned write data of head entry
mem_mask  output  4  byte enables of head entry (bit i = byte lane i)
mem_ack  input  1  cache accepted the current request
ld_addr  input  ADDR_W  load byte address being checked (combinational lookup)
ld_hit  output  1  youngest matching entry covers all 4 bytes; forward ld_data
ld_data  output  DATA_W  data of youngest matching entry when ld_hit, else 0
ld_conflict  output  1  a matching entry exists but the youngest match is partial; load must stall
empty  output  1  no entries held
count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (rst high at a rising edge): head = tail = count = 0, FSM = IDLE, all entry valid bits cleared. Next cycle: mem_req=0, in_ready=1, empty=1, ld_hit=0, ld_conflict=0, ld_data=0. mem_addr/mem_data/mem_mask are don't-care while mem_req=0. A request in flight is abandoned; a mem_ack arriving with rst is ignored.
- Entry formation at enqueue, with b = in_addr[1:0]:
  - SB: mask = 1 << b; data = in_data[7:0] placed in lane b, other lanes 0.
  - SH: lane base = {in_addr[1],0}; mask = 0011 or 1100; data = in_data[15:0] shifted accordingly; in_addr[0] ignored.
  - SW: mask = 1111; data = in_data; in_addr[1:0] ignored.
  - Word address = in_addr[ADDR_W-1:2].
- Enqueue: when in_valid && in_ready at an edge, write entry at tail; tail wraps DEPTH-1 -> 0.
- in_ready = (count < DEPTH), derived from the registered count. A full buffer refuses input even when a pop happens in the same cycle.
- Dequeue FSM:
  - IDLE: mem_req=0. If count != 0, go to REQ at the next edge.
  - REQ: mem_req=1; mem_addr/data/mask reflect the head entry and stay stable until ack.
    - On an edge with mem_ack=1: pop head (head wraps); stay in REQ if count-after-pop != 0, otherwise go to IDLE.
    - mem_ack while in IDLE is ignored.
- Latency: a store enqueued into an empty IDLE buffer at edge N has mem_req high in cycle N+1→N+2, i.e. after edge N+1. Back-to-back drain: one store per cycle while mem_ack is held high.
- Simultaneous enqueue and pop: count unchanged, both pointers advance. If the buffer holds one entry, the new entry becomes head next cycle and the FSM stays in REQ.
- count is updated as count + enq - pop. empty = (count == 0).
- Load lookup is combinational over valid entries, including the head entry currently in REQ. A match is an entry with word address == ld_addr[ADDR_W-1:2]. The youngest match (closest to tail) decides:
  - mask 1111: ld_hit=1, ld_data = that entry's data.
  - otherwise: ld_conflict=1, ld_hit=0.
  - No match: ld_hit=0, ld_conflict=0, ld_data=0.
- Pointer arithmetic is modulo DEPTH. count never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then SW addr 0x100 data 0xDEADBEEF (enqueue at edge 1) with mem_ack tied 1 -> mem_req=1 after edge 2 with mem_addr=0x100, mem_data=0xDEADBEEF, mem_mask=1111; empty=1 after edge 3.
- SB addr 0x203 data 0x5A -> mem_addr=0x200, mem_data=0x5A000000, mem_mask=1000. SH addr 0x206 data 0x1234 -> mem_data=0x12340000, mem_mask=1100.
- mem_ack held 0, enqueue DEPTH=4 stores -> in_ready=0, count=4. A 5th in_valid is dropped. Assert mem_ack for 1 cycle -> count=3, in_ready=1, mem_addr advances to the 2nd entry and is stable.
- Queue SW 0x40=0x11111111 then SW 0x40=0x22222222; ld_addr=0x42 -> ld_hit=1, ld_data=0x22222222. Add SB 0x41 -> ld_conflict=1, ld_hit=0. ld_addr=0x80 -> both 0.
- Full buffer with mem_ack=1 and in_valid=1 every cycle -> exactly one pop per cycle, enqueue accepted only when count<4, FIFO order preserved across pointer wrap (≥10 stores, compare mem sequence against a model).
- rst asserted while mem_req=1 and count=3 -> next cycle mem_req=0, count=0, empty=1, in_ready=1; subsequent store drains normally.
